// File: rtl/expu_collector.sv
// Collects row-result beats into a small FIFO and serializes strobed rows, lowest index first.
// Optional handshake counter output cnt_o is enabled by defining EXPU_COLLECTOR_CNT_EN.
module expu_collector #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned N_ROWS = 4,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic                                          clear_i,
  input  logic                                          valid_i,
  output logic                                          ready_o,
  input  logic [N_ROWS-1:0]                             strb_i,
  input  logic [N_ROWS*WIDTH-1:0]                       res_i,
  output logic                                          valid_o,
  input  logic                                          ready_i,
  output logic [WIDTH-1:0]                              data_o,
  output logic [((N_ROWS > 1) ? $clog2(N_ROWS) : 1)-1:0] row_o,
`ifdef EXPU_COLLECTOR_CNT_EN
  output logic [31:0]                                   cnt_o,
`endif
  output logic                                          last_o
);

  localparam int unsigned RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [N_ROWS*WIDTH-1:0] res_mem  [DEPTH];
  logic [N_ROWS-1:0]       strb_mem [DEPTH];

  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           count;
  logic [RW-1:0]           cursor;

  logic [N_ROWS*WIDTH-1:0] head_res;
  logic [N_ROWS-1:0]       head_strb;
  logic [RW-1:0]           cur_row;
  logic [WIDTH-1:0]        cur_data;
  logic                    cur_last;
  logic                    found;
  logic [31:0]             cursor_ext;

  logic                    push, out_hs, pop;

  assign ready_o = (count < CW'(DEPTH)) & ~rst_i & ~clear_i;
  assign valid_o = (count != '0) & ~rst_i & ~clear_i;

  assign push   = valid_i & ready_o & (|strb_i);
  assign out_hs = valid_o & ready_i;
  assign pop    = out_hs & cur_last;

  assign head_res   = res_mem[rd_ptr];
  assign head_strb  = strb_mem[rd_ptr];
  assign cursor_ext = {{(32-RW){1'b0}}, cursor};

  // The cursor marks the lowest row still owed; the current row is the first strobed
  // row at or above it, so unstrobed rows are skipped without any extra cycle.
  always_comb begin
    cur_row  = '0;
    cur_data = '0;
    cur_last = 1'b1;
    found    = 1'b0;
    for (int unsigned r = 0; r < N_ROWS; r++) begin
      if (head_strb[r] && (r >= cursor_ext)) begin
        if (!found) begin
          found    = 1'b1;
          cur_row  = RW'(r);
          cur_data = head_res[r*WIDTH +: WIDTH];
        end else begin
          cur_last = 1'b0;
        end
      end
    end
  end

  assign data_o = cur_data;
  assign row_o  = cur_row;
  assign last_o = cur_last;

  always_ff @(posedge clk_i) begin
    if (push) begin
      res_mem[wr_ptr]  <= res_i;
      strb_mem[wr_ptr] <= strb_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      cursor <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pop)         cursor <= '0;
      else if (out_hs) cursor <= cur_row + 1'b1;
    end
  end

`ifdef EXPU_COLLECTOR_CNT_EN
  logic [31:0] hs_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) hs_cnt <= '0;
    else if (out_hs)      hs_cnt <= hs_cnt + 32'd1;
  end

  assign cnt_o = hs_cnt;
`endif

endmodule

// File: doc/expu_collector.md
EXPU_COLLECTOR -- requirements
Module: expu_collector

Interface
REQ-001 SHALL have parameter WIDTH, default 16, element width in bits.
REQ-002 SHALL have parameter N_ROWS, default 4, rows per input beat (>=1).
REQ-003 SHALL have parameter DEPTH, default 4, beat buffer depth (power of two, >=2).
REQ-004 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port clear_i  input  1  synchronous soft clear.
REQ-007 SHALL have port valid_i  input  1  upstream beat valid (from exp pipeline valid_o).
REQ-008 SHALL have port ready_o  output  1  beat accepted when valid_i & ready_o.
REQ-009 SHALL have port strb_i  input  N_ROWS  per-row valid mask of the beat.
REQ-010 SHALL have port res_i  input  N_ROWS*WIDTH  row results; row r at bits [r*WIDTH +: WIDTH].
REQ-011 SHALL have port valid_o  output  1  serialized word valid.
REQ-012 SHALL have port ready_i  input  1  downstream accepts word when valid_o & ready_i.
REQ-013 SHALL have port data_o  output  WIDTH  serialized row result.
REQ-014 SHALL have port row_o  output  max(1,$clog2(N_ROWS))  row index of data_o.
REQ-015 SHALL have port last_o  output  1  data_o is the final strobed row of its beat.

Function
REQ-016 SHALL store each accepted beat (res_i, strb_i) in a DEPTH-entry FIFO; ready_o = (count < DEPTH) & ~rst_i & ~clear_i, with no combinational path from ready_i or valid_i.
REQ-017 SHALL accept and discard beats with strb_i == 0 (no FIFO write).
REQ-018 SHALL make a beat written at edge N visible on valid_o/data_o in the cycle following edge N (1-cycle latency, empty FIFO).
REQ-019 SHALL assert valid_o iff FIFO non-empty; data_o/row_o/last_o SHALL be combinational from head entry and row cursor.
REQ-020 SHALL emit strobed rows of the head beat in ascending row index, one per output handshake, skipping unstrobed rows with zero bubble cycles.
REQ-021 SHALL assert last_o when no higher-index strobed row remains; on handshake with last_o, head SHALL pop and cursor SHALL reset to the next beat's lowest strobed row.
REQ-022 SHALL keep data_o/row_o/last_o stable while valid_o & ~ready_i.
REQ-023 SHALL handle simultaneous push and pop: count unchanged, pointers both advance, wrap modulo DEPTH.
REQ-024 SHALL, when full, deassert ready_o; a pop in that cycle SHALL raise ready_o only in the next cycle.
REQ-025 SHALL on clear_i (priority over all handshakes) empty FIFO, zero pointers/count/cursor; data and strobe storage need not clear.

Reset
REQ-026 SHALL on rst_i zero pointers, count, cursor and (if present) cnt_o; valid_o=0, ready_o=0 during reset, ready_o=1 first cycle after release.
REQ-027 SHALL discard in-flight beats and partial serialization on reset mid-operation, with no output handshake completing in the reset cycle.

Configuration
REQ-028 SHALL, with macro EXPU_COLLECTOR_CNT_EN defined, add output cnt_o (32 bits): count of completed output handshakes, wrapping at 2^32, zeroed by rst_i/clear_i.
REQ-029 SHALL, without EXPU_COLLECTOR_CNT_EN, omit cnt_o and its counter entirely; other behaviour identical.

Verification
REQ-030 Single beat strb=4'b1010, res rows {0x3F80,0x4000,0x4040,0x4080}, ready_i=1 -> words (row1,0x4000,last=0),(row3,0x4080,last=1) in consecutive cycles, valid_o rises the cycle after acceptance.
REQ-031 Push 4 beats strb=4'hF with ready_i=0 -> ready_o=0 after 4th; raise ready_i -> 16 words in order, ready_o=1 the cycle after the first pop.
REQ-032 Beat strb=0 between two strb=4'h1 beats -> exactly 2 output words, both last_o=1.
REQ-033 Continuous valid_i & ready_i with strb=4'h1 -> 1 word/cycle sustained, count stays 1, pointers wrap past DEPTH.
REQ-034 clear_i asserted mid-serialization (after row0 of strb=4'hF) -> valid_o=0 next cycle; next beat emits from its lowest strobed row.
REQ-035 EXPU_COLLECTOR_CNT_EN defined, 10 words emitted then rst_i one cycle -> cnt_o reads 10 then 0.
